cla_add_scheduler: RTL and testbench

//   Shares one 32-bit CLA adder instance between NREQ requesters using round-robin arbitration.

---
 rtl/cla_add_scheduler_pkg.sv | 37 +++
 rtl/cla_add_scheduler_cla.sv | 51 +++++
 rtl/cla_add_scheduler.sv | 145 ++++++++++++++
 tb/tb_cla_add_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_add_scheduler_pkg.sv
// Shared definitions for the word-serial CLA add scheduler.
//   CLA_WORD_W : width of the shared carry-lookahead adder
//   state_e    : scheduler FSM encoding (S_IDLE / S_RUN / S_DONE)
//   rr_pick    : round-robin pick of the first valid requester at or above ptr
package cla_add_scheduler_pkg;

  localparam int CLA_WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Searches valid[ptr], valid[ptr+1], ... with wrap at nreq (nreq <= 8).
  // Returns ptr when nothing is valid; callers qualify with |valid.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         nreq);
    logic [2:0] pick;
    bit         found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nreq && !found) begin
        idx = (int'(ptr) + i) % nreq;
        if (valid[idx]) begin
          pick  = 3'(idx);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cla_add_scheduler_cla.sv
// 32-bit carry-lookahead adder shared by the scheduler.
// Ports:
//   a, b   : CLA_WORD_W-bit operands
//   ini_c  : carry-in
//   sum    : a + b + ini_c (low CLA_WORD_W bits)
//   carry  : carry-out of the top bit
// Built from 4-bit lookahead groups with group generate/propagate chained
// across groups.
module cla_add_scheduler_cla
  import cla_add_scheduler_pkg::*;
(
  input  logic [CLA_WORD_W-1:0] a,
  input  logic [CLA_WORD_W-1:0] b,
  input  logic                  ini_c,
  output logic [CLA_WORD_W-1:0] sum,
  output logic                  carry
);

  localparam int NG = CLA_WORD_W / 4;

  function automatic logic [CLA_WORD_W:0] cla_word(input logic [CLA_WORD_W-1:0] x,
                                                   input logic [CLA_WORD_W-1:0] y,
                                                   input logic                  ci);
    logic [CLA_WORD_W-1:0] g, p, c;
    logic [NG:0]           gc;
    logic                  gg, gp;
    int                    j;
    g     = x & y;
    p     = x ^ y;
    c     = '0;
    gc    = '0;
    gc[0] = ci;
    for (int i = 0; i < NG; i++) begin
      j = 4 * i;
      // Carries inside the group come straight from the group carry-in.
      c[j]   = gc[i];
      c[j+1] = g[j] | (p[j] & gc[i]);
      c[j+2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & gc[i]);
      c[j+3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j])
             | (p[j+2] & p[j+1] & p[j] & gc[i]);
      gg = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1])
         | (p[j+3] & p[j+2] & p[j+1] & g[j]);
      gp = &p[j +: 4];
      gc[i+1] = gg | (gp & gc[i]);
    end
    return {gc[NG], p ^ c};
  endfunction

  assign {carry, sum} = cla_word(a, b, ini_c);

endmodule

// File: rtl/cla_add_scheduler.sv
// Round-robin scheduler that shares one 32-bit CLA between NREQ requesters
// and performs NWORDS*32-bit additions one word per cycle, low word first.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester request handshake (ready is a one-hot grant)
//   req_a, req_b         : packed operands, requester r at [r*W +: W]
//   req_cin, req_sub     : carry-in and subtract select per requester
//   rsp_valid/rsp_ready  : result handshake
//   rsp_sum, rsp_cout    : W-bit result and carry-out of the top word
//   rsp_id               : requester index that owns the result
//   busy                 : FSM not in IDLE
// Optional feature: define CLA_SCHED_SUB_EN to honour req_sub (A - B via
// inverted B and forced carry-in); otherwise req_sub is ignored.
module cla_add_scheduler
  import cla_add_scheduler_pkg::*;
#(
  parameter  int NWORDS = 2,
  parameter  int NREQ   = 2,
  localparam int W      = CLA_WORD_W * NWORDS,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic [IW-1:0]     rsp_id,
  output logic              busy
);

  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_e          state, state_d;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant_idx;
  logic            any_req;
  logic [KW-1:0]   k;
  logic            last_word;

  logic [W-1:0]    a_p0, b_p0;
  logic            cin_p0, sub_p0;
  logic            carry_p1;

  logic [CLA_WORD_W-1:0] a_word, b_word, sum_word;
  logic                  ini_c, carry_word;

  assign any_req   = |req_valid;
  assign grant_idx = IW'(rr_pick(8'(req_valid), 3'(rr_ptr), NREQ));
  assign last_word = (k == KW'(NWORDS - 1));
  assign busy      = (state != S_IDLE);

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !rst && any_req)
      req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (any_req)   state_d = S_RUN;
      S_RUN:   if (last_word) state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Stage p0: operands captured in the accept cycle
  always_ff @(posedge clk) begin
    if (state == S_IDLE && any_req) begin
      a_p0   <= req_a[int'(grant_idx) * W +: W];
      b_p0   <= req_b[int'(grant_idx) * W +: W];
      cin_p0 <= req_cin[grant_idx];
      sub_p0 <= req_sub[grant_idx];
    end
  end

  assign a_word = a_p0[CLA_WORD_W * int'(k) +: CLA_WORD_W];

`ifdef CLA_SCHED_SUB_EN
  assign b_word = sub_p0 ? ~b_p0[CLA_WORD_W * int'(k) +: CLA_WORD_W]
                         :  b_p0[CLA_WORD_W * int'(k) +: CLA_WORD_W];
  assign ini_c  = (k == '0) ? (sub_p0 | cin_p0) : carry_p1;
`else
  logic unused_sub;
  assign unused_sub = sub_p0;
  assign b_word = b_p0[CLA_WORD_W * int'(k) +: CLA_WORD_W];
  assign ini_c  = (k == '0) ? cin_p0 : carry_p1;
`endif

  cla_add_scheduler_cla u_cla (
    .a     (a_word),
    .b     (b_word),
    .ini_c (ini_c),
    .sum   (sum_word),
    .carry (carry_word)
  );

  // Stage p1: one word per RUN cycle; carry chains to the next word
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      k         <= '0;
      carry_p1  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            rr_ptr <= IW'((int'(grant_idx) + 1) % NREQ);
            k      <= '0;
            rsp_id <= grant_idx;
          end
        end
        S_RUN: begin
          rsp_sum[CLA_WORD_W * int'(k) +: CLA_WORD_W] <= sum_word;
          carry_p1 <= carry_word;
          if (last_word) begin
            rsp_cout  <= carry_word;
            rsp_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_add_scheduler.sv
// Scoreboard bench for cla_add_scheduler (NWORDS=2, NREQ=2).
// Grants observed on req_ready push the requester's hand-computed expected
// result; a monitor pops and compares on every response handshake.
module tb_cla_add_scheduler;

  localparam int NWORDS = 2;
  localparam int NREQ   = 2;
  localparam int W      = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [127:0]    req_a = '0;
  logic [127:0]    req_b = '0;
  logic [1:0]      req_cin = '0;
  logic [1:0]      req_sub = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [63:0]     rsp_sum;
  logic            rsp_cout;
  logic [0:0]      rsp_id;
  logic            busy;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          grant_cyc[$];
  int          grant_log[$];
  logic [63:0] e_sum[2];
  logic        e_cout[2];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        prev_vld = 1'b0;

  cla_add_scheduler #(.NWORDS(NWORDS), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Grant watcher
  always @(negedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (req_ready[r]) begin
        sb.push_back('{e_sum[r], e_cout[r], r});
        grant_cyc.push_back(cyc);
        grant_log.push_back(r);
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rsp_valid && !prev_vld) begin
      if (grant_cyc.size() == 0) fail("latency_no_grant");
      else begin
        int g;
        g = grant_cyc.pop_front();
        chk("latency", 64'(cyc - g), 64'(NWORDS + 1));
      end
    end
    prev_vld <= rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) fail("unexpected_rsp");
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_sum", rsp_sum, e.sum);
        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
      end
    end
  end

  task automatic set_req(input int r, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub,
                         input logic [63:0] es, input logic ec);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_cin[r]      = cin;
    req_sub[r]      = sub;
    e_sum[r]        = es;
    e_cout[r]       = ec;
    req_valid[r]    = 1'b1;
  endtask

  task automatic wait_grant(input int r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 200);
    if (!req_ready[r]) fail("grant_timeout");
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic issue(input int r, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub,
                       input logic [63:0] es, input logic ec);
    set_req(r, a, b, cin, sub, es, ec);
    wait_grant(r);
  endtask

  task automatic wait_grants(input int n);
    int t;
    t = 0;
    while (grant_log.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (grant_log.size() < n) fail("grants_timeout");
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cap_sum;
    logic [0:0]  cap_id;
    int          n;
    int          exp_order[4];
    exp_order = '{0, 1, 0, 1};

    // Reset state, with both requesters already asserting valid
    set_req(0, 64'd1,  64'd2,  1'b0, 1'b0, 64'd3,  1'b0);
    set_req(1, 64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_sum", rsp_sum, 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    grant_log.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin fairness with both valid held
    wait_grants(4);
    req_valid = 2'b00;
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));
    drain();

    // Carry from word 0 into word 1
    issue(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
    drain();

    // Full-width overflow through b and through cin
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1);
    drain();
    issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
    drain();

    // Subtract request
`ifdef CLA_SCHED_SUB_EN
    issue(0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
`else
    issue(0, 64'd5, 64'd7, 1'b0, 1'b1, 64'd12, 1'b0);
`endif
    drain();

    // Back-pressure in DONE with a competing request pending
    rsp_ready = 1'b0;
    issue(0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
          64'h2345_6789_ABCD_F001, 1'b0);
    set_req(1, 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    if (!rsp_valid) fail("bp_rsp_timeout");
    cap_sum = rsp_sum;
    cap_id  = rsp_id;
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", {60'd0, rsp_valid, (rsp_sum == cap_sum), (rsp_id == cap_id), (req_ready == 2'b00)},
          64'hF);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_vld", 64'(rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'd2);
    @(posedge clk);
    #1 req_valid = 2'b00;
    drain();

    // Reset in the second RUN cycle aborts the operation
    issue(0, 64'hDEAD_BEEF_0000_0001, 64'd1, 1'b0, 1'b0, 64'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    grant_cyc.delete();
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    grant_log.delete();
    set_req(0, 64'd3,   64'd4, 1'b0, 1'b0, 64'd7,   1'b0);
    set_req(1, 64'd100, 64'd1, 1'b0, 1'b0, 64'd101, 1'b0);
    wait_grants(2);
    req_valid = 2'b00;
    if (grant_log.size() >= 2) begin
      chk("abort_rr_first", 64'(grant_log[0]), 64'd0);
      chk("abort_rr_second", 64'(grant_log[1]), 64'd1);
    end
    drain();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
